// File: rtl/pri_queue_param.sv
// Sorted priority queue built as a systolic array of DEPTH slots, best key at slot 0.
// Each slot picks its next value from itself, its neighbours or the incoming key.
module pri_queue_param #(
  parameter int W         = 8,
  parameter int DEPTH     = 6,
  parameter bit MAX_FIRST = 1'b1
) (
  input  logic                         ck,
  input  logic                         r_n,
  input  logic                         clear,
  input  logic                         loadIn,
  input  logic                         shiftOut,
  input  logic [W-1:0]                 newVal,
  output logic [W-1:0]                 top,
  output logic                         top_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         drop,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]     val_q [DEPTH];
  logic [W-1:0]     val_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    count_q, count_d;
  logic             drop_q, drop_d;
  logic             underflow_q, underflow_d;

  logic [DEPTH:0]   beats;
  logic [W-1:0]     abv_val [DEPTH];
  logic [W-1:0]     blw_val [DEPTH];
  logic [DEPTH-1:0] abv_vld, abv_beats, blw_vld;
  logic             full_w, empty_w;

  function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b);
    return MAX_FIRST ? (a > b) : (a < b);
  endfunction

  // beats is a thermometer (0s then 1s) because slots stay sorted and valid-above-invalid
  for (genvar i = 0; i < DEPTH; i++) begin : g_nbr
    assign beats[i] = !vld_q[i] || better(newVal, val_q[i]);
    if (i == 0) begin : g_first
      assign abv_val[i]   = '0;
      assign abv_vld[i]   = 1'b0;
      assign abv_beats[i] = 1'b0;
    end else begin : g_mid
      assign abv_val[i]   = val_q[i-1];
      assign abv_vld[i]   = vld_q[i-1];
      assign abv_beats[i] = beats[i-1];
    end
    if (i == DEPTH-1) begin : g_last
      assign blw_val[i] = '0;
      assign blw_vld[i] = 1'b0;
    end else begin : g_below
      assign blw_val[i] = val_q[i+1];
      assign blw_vld[i] = vld_q[i+1];
    end
  end
  assign beats[DEPTH] = 1'b1;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  always_comb begin
    val_d       = val_q;
    vld_d       = vld_q;
    count_d     = count_q;
    drop_d      = 1'b0;
    underflow_d = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) val_d[i] = '0;
      vld_d   = '0;
      count_d = '0;
    end else if (loadIn && shiftOut && !empty_w) begin
      // Replace: view the array shifted up by one, then insert; slots already beaten stay put
      for (int i = 0; i < DEPTH; i++) begin
        if (i != 0 && beats[i]) begin
          val_d[i] = val_q[i];
          vld_d[i] = vld_q[i];
        end else if (beats[i+1]) begin
          val_d[i] = newVal;
          vld_d[i] = 1'b1;
        end else begin
          val_d[i] = blw_val[i];
          vld_d[i] = blw_vld[i];
        end
      end
    end else if (loadIn) begin
      // A full queue whose bottom is not beaten has an all-zero beats vector, so nothing moves
      for (int i = 0; i < DEPTH; i++) begin
        if (abv_beats[i]) begin
          val_d[i] = abv_val[i];
          vld_d[i] = abv_vld[i];
        end else if (beats[i]) begin
          val_d[i] = newVal;
          vld_d[i] = 1'b1;
        end
      end
      underflow_d = shiftOut;
      if (full_w) drop_d = 1'b1;
      else        count_d = count_q + CW'(1);
    end else if (shiftOut) begin
      if (empty_w) begin
        underflow_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          val_d[i] = blw_val[i];
          vld_d[i] = blw_vld[i];
        end
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge ck) begin
    if (!r_n) begin
      for (int i = 0; i < DEPTH; i++) val_q[i] <= '0;
      vld_q       <= '0;
      count_q     <= '0;
      drop_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) val_q[i] <= val_d[i];
      vld_q       <= vld_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      underflow_q <= underflow_d;
    end
  end

  assign top       = val_q[0];
  assign top_valid = vld_q[0];
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign drop      = drop_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pri_queue_param.sv
// Bench for pri_queue_param: a max-first 4-slot instance driven by directed vectors and a
// min-first 8-slot instance driven randomly, both compared every cycle to sorted-list models.
module tb_pri_queue_param;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  // max-first, W=8, DEPTH=4
  logic       r_n1 = 1'b0, clear1 = 1'b0, load1 = 1'b0, pop1 = 1'b0;
  logic [7:0] val1 = '0;
  logic [7:0] top1;
  logic       tv1, full1, empty1, drop1, uf1;
  logic [2:0] cnt1;

  // min-first, W=10, DEPTH=8
  logic       r_n2 = 1'b0, clear2 = 1'b0, load2 = 1'b0, pop2 = 1'b0;
  logic [9:0] val2 = '0;
  logic [9:0] top2;
  logic       tv2, full2, empty2, drop2, uf2;
  logic [3:0] cnt2;

  pri_queue_param #(.W(8), .DEPTH(4), .MAX_FIRST(1'b1)) dut1 (
    .ck(ck), .r_n(r_n1), .clear(clear1), .loadIn(load1), .shiftOut(pop1), .newVal(val1),
    .top(top1), .top_valid(tv1), .count(cnt1), .full(full1), .empty(empty1),
    .drop(drop1), .underflow(uf1));

  pri_queue_param #(.W(10), .DEPTH(8), .MAX_FIRST(1'b0)) dut2 (
    .ck(ck), .r_n(r_n2), .clear(clear2), .loadIn(load2), .shiftOut(pop2), .newVal(val2),
    .top(top2), .top_valid(tv2), .count(cnt2), .full(full2), .empty(empty2),
    .drop(drop2), .underflow(uf2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m1[$];
  int m2[$];
  bit m1_drop = 1'b0, m1_uf = 1'b0, m2_drop = 1'b0, m2_uf = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit better(input int a, input int b, input bit mf);
    return mf ? (a > b) : (a < b);
  endfunction

  // Insert below any equal keys: first position whose key the new one strictly beats
  task automatic m1_insert(input int v);
    int idx;
    idx = m1.size();
    for (int k = 0; k < m1.size(); k++)
      if (better(v, m1[k], 1'b1)) begin idx = k; break; end
    m1.insert(idx, v);
  endtask

  task automatic m2_insert(input int v);
    int idx;
    idx = m2.size();
    for (int k = 0; k < m2.size(); k++)
      if (better(v, m2[k], 1'b0)) begin idx = k; break; end
    m2.insert(idx, v);
  endtask

  always @(posedge ck) begin
    m1_drop = 1'b0;
    m1_uf   = 1'b0;
    if (!r_n1 || clear1) m1.delete();
    else if (load1 && pop1 && m1.size() > 0) begin
      void'(m1.pop_front());
      m1_insert(int'(val1));
    end else if (load1) begin
      m1_uf = pop1;
      if (m1.size() < 4) m1_insert(int'(val1));
      else begin
        m1_drop = 1'b1;
        if (better(int'(val1), m1[3], 1'b1)) begin
          void'(m1.pop_back());
          m1_insert(int'(val1));
        end
      end
    end else if (pop1) begin
      if (m1.size() == 0) m1_uf = 1'b1;
      else void'(m1.pop_front());
    end
  end

  always @(posedge ck) begin
    m2_drop = 1'b0;
    m2_uf   = 1'b0;
    if (!r_n2 || clear2) m2.delete();
    else if (load2 && pop2 && m2.size() > 0) begin
      void'(m2.pop_front());
      m2_insert(int'(val2));
    end else if (load2) begin
      m2_uf = pop2;
      if (m2.size() < 8) m2_insert(int'(val2));
      else begin
        m2_drop = 1'b1;
        if (better(int'(val2), m2[7], 1'b0)) begin
          void'(m2.pop_back());
          m2_insert(int'(val2));
        end
      end
    end else if (pop2) begin
      if (m2.size() == 0) m2_uf = 1'b1;
      else void'(m2.pop_front());
    end
  end

  // Compare both instances against their models on every falling edge
  always @(negedge ck) begin
    if (chk_en) begin
      checkOutput("q1_top",       32'(top1),   32'((m1.size() > 0) ? m1[0] : 0));
      checkOutput("q1_top_valid", 32'(tv1),    32'(m1.size() > 0));
      checkOutput("q1_count",     32'(cnt1),   32'(m1.size()));
      checkOutput("q1_full",      32'(full1),  32'(m1.size() == 4));
      checkOutput("q1_empty",     32'(empty1), 32'(m1.size() == 0));
      checkOutput("q1_drop",      32'(drop1),  32'(m1_drop));
      checkOutput("q1_underflow", 32'(uf1),    32'(m1_uf));
      checkOutput("q2_top",       32'(top2),   32'((m2.size() > 0) ? m2[0] : 0));
      checkOutput("q2_top_valid", 32'(tv2),    32'(m2.size() > 0));
      checkOutput("q2_count",     32'(cnt2),   32'(m2.size()));
      checkOutput("q2_full",      32'(full2),  32'(m2.size() == 8));
      checkOutput("q2_empty",     32'(empty2), 32'(m2.size() == 0));
      checkOutput("q2_drop",      32'(drop2),  32'(m2_drop));
      checkOutput("q2_underflow", 32'(uf2),    32'(m2_uf));
    end
  end

  task automatic applyStimulus(input logic rn, input logic cl, input logic ld, input logic sh,
                               input logic [7:0] v);
    r_n1   = rn;
    clear1 = cl;
    load1  = ld;
    pop1   = sh;
    val1   = v;
    @(posedge ck);
    #1;
  endtask

  task automatic push(input logic [7:0] v);    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, v);   endtask
  task automatic pop();                        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'd0); endtask
  task automatic replace(input logic [7:0] v); applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, v);   endtask
  task automatic idle();                       applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0); endtask
  task automatic flush();                      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0); endtask

  initial begin
    int r;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd99);
    chk_en = 1'b1;
    checkOutput("reset_top",   32'(top1),   32'd0);
    checkOutput("reset_count", 32'(cnt1),   32'd0);
    checkOutput("reset_empty", 32'(empty1), 32'd1);
    r_n2 = 1'b1;

    // Fill, then drain in descending order
    push(8'd30); push(8'd10); push(8'd50); push(8'd20);
    checkOutput("fill_top",   32'(top1),  32'd50);
    checkOutput("fill_count", 32'(cnt1),  32'd4);
    checkOutput("fill_full",  32'(full1), 32'd1);
    pop(); checkOutput("drain_top_a", 32'(top1), 32'd30);
    pop(); checkOutput("drain_top_b", 32'(top1), 32'd20);
    pop(); checkOutput("drain_top_c", 32'(top1), 32'd10);
    pop(); checkOutput("drain_top_d", 32'(top1), 32'd0);
    checkOutput("drain_empty", 32'(empty1), 32'd1);

    // Overflow: worse key discarded, better key evicts bottom
    push(8'd50); push(8'd30); push(8'd20); push(8'd10);
    push(8'd5);
    checkOutput("ovf_drop_lose", 32'(drop1), 32'd1);
    checkOutput("ovf_top_lose",  32'(top1),  32'd50);
    idle();
    checkOutput("ovf_drop_clr",  32'(drop1), 32'd0);
    push(8'd40);
    checkOutput("ovf_drop_win",  32'(drop1), 32'd1);
    pop(); checkOutput("ovf_seq_a", 32'(top1), 32'd40);
    pop(); checkOutput("ovf_seq_b", 32'(top1), 32'd30);
    pop(); checkOutput("ovf_seq_c", 32'(top1), 32'd20);
    pop(); checkOutput("ovf_seq_d", 32'(cnt1), 32'd0);

    // Replace
    push(8'd50); push(8'd30);
    replace(8'd40);
    checkOutput("repl_top_a",   32'(top1), 32'd40);
    checkOutput("repl_count_a", 32'(cnt1), 32'd2);
    replace(8'd60);
    checkOutput("repl_top_b",   32'(top1), 32'd60);
    push(8'd20); push(8'd10);
    replace(8'd1);
    checkOutput("repl_full_drop",  32'(drop1), 32'd0);
    checkOutput("repl_full_top",   32'(top1),  32'd30);
    checkOutput("repl_full_count", 32'(cnt1),  32'd4);

    // Underflow
    flush();
    pop();
    checkOutput("uf_pop",       32'(uf1),  32'd1);
    checkOutput("uf_pop_count", 32'(cnt1), 32'd0);
    replace(8'd7);
    checkOutput("uf_repl",       32'(uf1),  32'd1);
    checkOutput("uf_repl_top",   32'(top1), 32'd7);
    checkOutput("uf_repl_count", 32'(cnt1), 32'd1);
    idle();

    // Ties, clear over a push, reset over a pending push
    flush();
    push(8'd5); push(8'd5); push(8'd7); push(8'd5);
    checkOutput("tie_top", 32'(top1), 32'd7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd9);
    checkOutput("clr_count", 32'(cnt1),   32'd0);
    checkOutput("clr_empty", 32'(empty1), 32'd1);
    push(8'd1); push(8'd2); push(8'd3); push(8'd4); push(8'd9);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd8);
    checkOutput("rst_top",   32'(top1), 32'd0);
    checkOutput("rst_count", 32'(cnt1), 32'd0);
    checkOutput("rst_drop",  32'(drop1), 32'd0);
    checkOutput("rst_tv",    32'(tv1),  32'd0);
    idle();

    // Random traffic on the min-first instance; small key range forces ties
    for (int n = 0; n < 200; n++) begin
      r      = $urandom_range(0, 99);
      clear2 = (r >= 97);
      load2  = (r < 40) || (r >= 70 && r < 97);
      pop2   = (r >= 40 && r < 97);
      val2   = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      @(posedge ck);
      #1;
    end
    clear2 = 1'b0; load2 = 1'b0; pop2 = 1'b0;
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
